// File: rtl/alu_result_collector.sv
// Collects one tagged result per capture strobe from the four ALU unit buses
// and buffers it in a first-word-fall-through FIFO drained by valid/ready.
module alu_result_collector #(
  parameter int Op_Width  = 16,
  parameter int Depth     = 8,
  parameter int Cnt_Width = 8
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         in_valid,
  input  logic [Op_Width-1:0]          Arith_OUT,
  input  logic [Op_Width-1:0]          Logic_OUT,
  input  logic [Op_Width-1:0]          CMP_OUT,
  input  logic [Op_Width-1:0]          Shift_OUT,
  input  logic                         Carry_OUT,
  input  logic                         Arith_FLAG,
  input  logic                         Logic_FLAG,
  input  logic                         CMP_FLAG,
  input  logic                         Shift_FLAG,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [Op_Width-1:0]          out_data,
  output logic [1:0]                   out_unit,
  output logic                         out_carry,
  output logic                         out_err,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(Depth):0]       count,
  output logic [Cnt_Width-1:0]         drop_cnt
);

  localparam int AW = $clog2(Depth);
  localparam int EW = Op_Width + 4;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(Depth);

  logic [EW-1:0]       mem [Depth];
  logic [AW-1:0]       wr_ptr_reg;
  logic [AW-1:0]       rd_ptr_reg;
  logic [AW:0]         count_reg;
  logic [Cnt_Width-1:0] drop_cnt_reg;

  logic [Op_Width-1:0] sel_data;
  logic [1:0]          sel_unit;
  logic                sel_carry;
  logic                sel_err;
  logic [3:0]          flags;
  logic                one_hot;
  logic                push;
  logic                pop;
  logic                drop;
  logic                is_full;
  logic                is_empty;
  logic [EW-1:0]       head;

  // Priority arith > logic > cmp > shift; err marks anything but a single flag.
  always_comb begin
    sel_data  = '0;
    sel_unit  = 2'd0;
    sel_carry = 1'b0;
    flags     = {Shift_FLAG, CMP_FLAG, Logic_FLAG, Arith_FLAG};
    one_hot   = (flags != 4'd0) && ((flags & (flags - 4'd1)) == 4'd0);
    sel_err   = !one_hot;
    if (Arith_FLAG) begin
      sel_data  = Arith_OUT;
      sel_unit  = 2'd0;
      sel_carry = Carry_OUT;
    end else if (Logic_FLAG) begin
      sel_data = Logic_OUT;
      sel_unit = 2'd1;
    end else if (CMP_FLAG) begin
      sel_data = CMP_OUT;
      sel_unit = 2'd2;
    end else if (Shift_FLAG) begin
      sel_data = Shift_OUT;
      sel_unit = 2'd3;
    end
  end

  assign is_full  = (count_reg == CNT_FULL);
  assign is_empty = (count_reg == '0);
  assign pop      = !is_empty && out_ready;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push     = in_valid && (!is_full || pop);
  assign drop     = in_valid && is_full && !pop;

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr_reg] <= {sel_err, sel_carry, sel_unit, sel_data};
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      drop_cnt_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
      if (drop && (drop_cnt_reg != '1)) begin
        drop_cnt_reg <= drop_cnt_reg + Cnt_Width'(1);
      end
    end
  end

  // Head is gated so unwritten memory never leaks out while empty.
  assign head      = is_empty ? '0 : mem[rd_ptr_reg];
  assign out_data  = head[Op_Width-1:0];
  assign out_unit  = head[Op_Width+1:Op_Width];
  assign out_carry = head[Op_Width+2];
  assign out_err   = head[Op_Width+3];
  assign out_valid = !is_empty;
  assign full      = is_full;
  assign empty     = is_empty;
  assign count     = count_reg;
  assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed self-checking bench for alu_result_collector (Depth 8, 16-bit results).
module tb_alu_result_collector;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] Arith_OUT = '0, Logic_OUT = '0, CMP_OUT = '0, Shift_OUT = '0;
  logic        Carry_OUT = 1'b0;
  logic        Arith_FLAG = 1'b0, Logic_FLAG = 1'b0, CMP_FLAG = 1'b0, Shift_FLAG = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [1:0]  out_unit;
  logic        out_carry, out_err, full, empty;
  logic [3:0]  count;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_errs   = 0;

  alu_result_collector #(.Op_Width(16), .Depth(8), .Cnt_Width(8)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid),
    .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT), .CMP_OUT(CMP_OUT), .Shift_OUT(Shift_OUT),
    .Carry_OUT(Carry_OUT), .Arith_FLAG(Arith_FLAG), .Logic_FLAG(Logic_FLAG),
    .CMP_FLAG(CMP_FLAG), .Shift_FLAG(Shift_FLAG),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_unit(out_unit),
    .out_carry(out_carry), .out_err(out_err), .full(full), .empty(empty),
    .count(count), .drop_cnt(drop_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // One capture; flags = {shift, cmp, logic, arith}.
  task automatic capture(input logic [3:0] fl, input logic [15:0] a, input logic [15:0] l,
                         input logic [15:0] c, input logic [15:0] s, input logic cy);
    {Shift_FLAG, CMP_FLAG, Logic_FLAG, Arith_FLAG} = fl;
    Arith_OUT = a; Logic_OUT = l; CMP_OUT = c; Shift_OUT = s; Carry_OUT = cy;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    {Shift_FLAG, CMP_FLAG, Logic_FLAG, Arith_FLAG} = 4'b0000;
    Carry_OUT = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_q [8];

    // Reset state
    #2;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_data", out_data, 0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    // out_ready while empty does nothing
    pop_one();
    check("empty_ready_count", count, 0);

    // 4 + 2 = 6 on the arith unit, no carry
    capture(4'b0001, 16'd6, 16'h1111, 16'h2222, 16'h3333, 1'b0);
    check("add_valid", out_valid, 1);
    check("add_data", out_data, 16'd6);
    check("add_unit", out_unit, 0);
    check("add_carry", out_carry, 0);
    check("add_err", out_err, 0);
    check("add_count", count, 1);
    pop_one();
    check("add_popped_empty", empty, 1);

    // FFFF + 1 = 0 with carry out
    capture(4'b0001, 16'h0000, 16'h0, 16'h0, 16'h0, 1'b1);
    check("carry_set", out_carry, 1);
    pop_one();

    // AAAA & CCCC on logic unit, Carry_OUT high must not leak
    capture(4'b0010, 16'h1234, 16'h8888, 16'h0, 16'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold_data_%0d", i), out_data, 16'h8888);
      check($sformatf("hold_unit_%0d", i), out_unit, 1);
      cycle();
    end
    check("logic_carry", out_carry, 0);
    pop_one();
    check("logic_popped_empty", empty, 1);

    // Fill with 1..8
    for (int i = 1; i <= 8; i++) capture(4'b0001, 16'(i), 16'h0, 16'h0, 16'h0, 1'b0);
    check("fill_full", full, 1);
    check("fill_count", count, 8);
    capture(4'b0001, 16'd9, 16'h0, 16'h0, 16'h0, 1'b0);
    check("drop_one", drop_cnt, 1);
    check("drop_count", count, 8);
    check("drop_head", out_data, 1);

    // Push and pop on the same edge while full
    Arith_OUT = 16'h00FF; Arith_FLAG = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0; out_ready = 1'b0; Arith_FLAG = 1'b0;
    check("pp_count", count, 8);
    check("pp_drop", drop_cnt, 1);

    exp_q = '{16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'h00FF};
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_%0d", i), out_data, 32'(exp_q[i]));
      pop_one();
    end
    check("drain_empty", empty, 1);

    // No flags
    capture(4'b0000, 16'h5555, 16'h6666, 16'h7777, 16'h8888, 1'b1);
    check("noflag_err", out_err, 1);
    check("noflag_data", out_data, 0);
    check("noflag_unit", out_unit, 0);
    pop_one();

    // CMP + Shift: cmp wins
    capture(4'b1100, 16'h0, 16'h0, 16'd2, 16'd7, 1'b0);
    check("multi_unit", out_unit, 2);
    check("multi_data", out_data, 2);
    check("multi_err", out_err, 1);
    pop_one();

    // Logic + Shift: logic wins; all flags: arith wins with carry
    capture(4'b1010, 16'h0, 16'h0AAA, 16'h0, 16'h0BBB, 1'b1);
    check("ls_unit", out_unit, 1);
    check("ls_data", out_data, 16'h0AAA);
    check("ls_carry", out_carry, 0);
    pop_one();
    capture(4'b1111, 16'h0C0C, 16'h1, 16'h2, 16'h3, 1'b1);
    check("all_unit", out_unit, 0);
    check("all_data", out_data, 16'h0C0C);
    check("all_carry", out_carry, 1);
    check("all_err", out_err, 1);
    pop_one();

    // Shift alone
    capture(4'b1000, 16'h0, 16'h0, 16'h0, 16'hF00D, 1'b1);
    check("shift_unit", out_unit, 3);
    check("shift_data", out_data, 16'hF00D);
    check("shift_err", out_err, 0);
    pop_one();

    // Drop counter saturation
    for (int i = 0; i < 8; i++) capture(4'b0001, 16'(i), 16'h0, 16'h0, 16'h0, 1'b0);
    Arith_FLAG = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 260; i++) cycle();
    in_valid = 1'b0; Arith_FLAG = 1'b0;
    check("drop_sat", drop_cnt, 8'hFF);
    check("drop_sat_count", count, 8);

    // Asynchronous reset mid-cycle
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 3; i++) capture(4'b0001, 16'(i + 16'h40), 16'h0, 16'h0, 16'h0, 1'b0);
    check("pre_rst_count", count, 3);
    capture(4'b0001, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    #2 RST = 1'b0;
    #1;
    check("arst_empty", empty, 1);
    check("arst_valid", out_valid, 0);
    check("arst_count", count, 0);
    check("arst_drop", drop_cnt, 0);
    check("arst_data", out_data, 0);
    @(negedge CLK);
    RST = 1'b1;
    capture(4'b0010, 16'h0, 16'hBEEF, 16'h0, 16'h0, 1'b0);
    check("post_rst_data", out_data, 16'hBEEF);
    check("post_rst_count", count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/alu_result_collector.md
Name: alu_result_collector

Overview:
- Downstream stage of the 16-bit ALU top.
- Each cycle a capture strobe is asserted, it samples the four unit result buses and their unit flags.
- It selects the one active result, tags it with unit code, carry and error bit, and buffers it in a first-word-fall-through FIFO.
- The FIFO drains through a valid/ready handshake to the consumer (bus interface or host readback), with occupancy and drop statistics.

Parameters:
- Op_Width, 16, width of ALU operands and results.
- Depth, 8, FIFO entries; power of two, minimum 2.
- Cnt_Width, 8, width of saturating drop counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- in_valid  in  1  capture strobe: ALU outputs this cycle are a result to collect.
- Arith_OUT  in  Op_Width  ALU arithmetic result.
- Logic_OUT  in  Op_Width  ALU logic result.
- CMP_OUT  in  Op_Width  ALU compare result.
- Shift_OUT  in  Op_Width  ALU shift result.
- Carry_OUT  in  1  ALU arithmetic carry.
- Arith_FLAG, Logic_FLAG, CMP_FLAG, Shift_FLAG  in  1 each  unit-active flags.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts head entry.
- out_data  out  Op_Width  head result.
- out_unit  out  2  head unit code: 0 arith, 1 logic, 2 cmp, 3 shift.
- out_carry  out  1  head carry (arith entries only, else 0).
- out_err  out  1  head entry had zero or multiple flags set.
- full  out  1  FIFO holds Depth entries.
- empty  out  1  FIFO holds 0 entries.
- count  out  log2(Depth)+1  current occupancy.
- drop_cnt  out  Cnt_Width  pushes rejected while full; saturates at all-ones.

Behaviour:
- Reset (RST low, asynchronous): pointers 0, count 0, empty 1, full 0, out_valid 0, drop_cnt 0. out_data/out_unit/out_carry/out_err read 0 while empty. Memory contents are not reset.
- Reset mid-operation discards all stored entries immediately. The first capture after RST returns high is treated normally.
- Selection (combinational, on sampled inputs):
  - Exactly one flag high: data is that unit's bus, unit is its code, err 0.
  - Carry is Carry_OUT when the unit is arith, otherwise 0.
  - Zero flags high: data 0, unit 0, carry 0, err 1.
  - Two or more flags high: priority arith > logic > cmp > shift for data and unit, carry rule as above, err 1.
- Push: in_valid high at a rising edge and the FIFO is not full. A full FIFO also accepts the push if a pop occurs at the same edge.
- Pop: out_valid and out_ready both high at a rising edge.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pop and push on an empty FIFO is impossible, since out_valid is 0 when empty.
- Latency (FWFT): an entry pushed at edge k is visible on the out_* ports with out_valid 1 immediately after edge k if the FIFO was empty.
- out_* hold stable while out_valid is 1 and out_ready is 0.
- Pointers are log2(Depth) bits and wrap modulo Depth. full = (count == Depth), empty = (count == 0).
- Drop: in_valid high while full with no same-edge pop. The entry is discarded, FIFO state is unchanged, and drop_cnt increments unless it is already all-ones.
- out_ready while empty has no effect.

Test Plan:
- Reset then A=4, B=2, add. Arith_OUT=6, Arith_FLAG only, in_valid 1 cycle -> next cycle out_valid 1, out_data 6, out_unit 0, out_carry per Carry_OUT, out_err 0, count 1.
- Logic AND with A=16'hAAAA, B=16'hCCCC, Logic_FLAG only, out_ready 0 -> out_data 16'h8888, out_unit 1, held stable for 5 cycles. Raise out_ready 1 cycle -> empty 1.
- Push 8 entries (values 1..8) with out_ready 0 -> full 1, count 8. Ninth push with value 9 -> drop_cnt 1. Drain -> order 1..8, value 9 absent.
- Full FIFO, in_valid and out_ready high at the same edge with value 16'h00FF -> count stays 8, drop_cnt unchanged, 16'h00FF is the last entry drained.
- in_valid with no flags -> out_err 1, out_data 0. CMP_FLAG and Shift_FLAG both set, CMP_OUT=2 -> out_unit 2, out_data 2, out_err 1.
- Push 3 entries, assert RST low mid-cycle -> empty 1, out_valid 0, count 0, drop_cnt 0 without waiting for a clock edge.
